// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter: round-robin scheduler streaming one requester's packet at a time onto a shared AXI-Stream master port
module axis_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int ID_W    = 2
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_dready,
  output logic [NUM_REQ-1:0]        req_done,
  input  logic                      tready,
  output logic                      tvalid,
  output logic [DATA_W-1:0]         tdata,
  output logic                      tlast,
  output logic [ID_W-1:0]           tdest,
  output logic                      busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] last_grant, grant;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic hs, last_beat;
  assign hs = tvalid & tready;
  assign last_beat = beat_cnt == len_q;
  assign tlast = tvalid & last_beat;
  assign busy = state == SEND;
  assign tdata = req_data[tdest*DATA_W +: DATA_W];
  assign req_dready = hs ? NUM_REQ'(1) << tdest : '0;
  // Scan downward so the closest requester after last_grant is assigned last and wins
  always_comb begin
    grant = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(last_grant) + k) % NUM_REQ]) grant = ID_W'((int'(last_grant) + k) % NUM_REQ);
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (|req ? SEND : IDLE) : (hs && last_beat ? IDLE : SEND);
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      tvalid     <= 1'b0;
      tdest      <= '0;
      req_done   <= '0;
      beat_cnt   <= '0;
      len_q      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      req_done <= '0;
      if (state == IDLE && |req) begin
        tdest      <= grant;
        last_grant <= grant;
        len_q      <= req_len[grant*LEN_W +: LEN_W];
        beat_cnt   <= '0;
        tvalid     <= 1'b1;
      end else if (state == SEND && hs) begin
        if (last_beat) begin
          tvalid   <= 1'b0;
          req_done <= NUM_REQ'(1) << tdest;
        end else beat_cnt <= beat_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_axis_tx_arbiter.sv
// tb_axis_tx_arbiter: directed table, corner-case sequences and randomized traffic against a packet-level reference model
module tb_axis_tx_arbiter;
  localparam int N = 4, DW = 32, LW = 8, IW = 2;
  logic aclk = 1'b0, areset;
  logic [N-1:0] req, req_dready, req_done;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic tready, tvalid, tlast, busy;
  logic [DW-1:0] tdata;
  logic [IW-1:0] tdest;
  int checks = 0, errors = 0;

  axis_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
    .aclk(aclk), .areset(areset), .req(req), .req_len(req_len), .req_data(req_data),
    .req_dready(req_dready), .req_done(req_done), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tlast(tlast), .tdest(tdest), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_len(input int l);
    for (int i = 0; i < N; i++) req_len[i*LW +: LW] = LW'(l);
  endtask

  typedef struct {
    logic [N-1:0] req; int len; logic rdy;
    logic v; int d; logic l; logic [N-1:0] dr; logic [N-1:0] dn;
  } vec_t;
  vec_t tbl[12];

  // reference model state
  bit m_valid;
  int m_dest, m_last, m_left, idx;
  logic [N-1:0] m_done, nd, exp_dr;
  int wcnt[N];
  int beats, lasts, lastpos, n;

  initial begin
    tbl[0]  = '{4'b0000, 2, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 2, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0000, 2, 1'b1, 1'b1, 0, 1'b0, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0000, 2, 1'b1, 1'b1, 0, 1'b0, 4'b0001, 4'b0000};
    tbl[4]  = '{4'b0000, 2, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[5]  = '{4'b0000, 0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0001};
    tbl[6]  = '{4'b0101, 0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0101, 0, 1'b1, 1'b1, 2, 1'b1, 4'b0100, 4'b0000};
    tbl[8]  = '{4'b0001, 0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0100};
    tbl[9]  = '{4'b0000, 0, 1'b1, 1'b1, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[10] = '{4'b0000, 0, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 4'b0001};
    tbl[11] = '{4'b0000, 0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 4'b0000};

    areset = 1'b1; req = '0; tready = 1'b0; set_len(0);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hD0 + i;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // directed table: single 3-beat packet, simultaneous requests, tready with no tvalid
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; set_len(tbl[i].len); tready = tbl[i].rdy;
      @(negedge aclk);
      chk($sformatf("row%0d tvalid", i), tvalid, tbl[i].v);
      chk($sformatf("row%0d busy", i), busy, tbl[i].v);
      chk($sformatf("row%0d tlast", i), tlast, tbl[i].l);
      chk($sformatf("row%0d dready", i), req_dready, tbl[i].dr);
      chk($sformatf("row%0d done", i), req_done, tbl[i].dn);
      if (tbl[i].v) begin
        chk($sformatf("row%0d tdest", i), tdest, tbl[i].d);
        chk($sformatf("row%0d tdata", i), tdata, 32'hD0 + tbl[i].d);
      end
      @(posedge aclk); #1;
    end

    // backpressure on beat 2 of a 4-beat packet from requester 1
    req = 4'b0010; set_len(3); tready = 1'b1; req_data[DW +: DW] = 32'hB0;
    @(posedge aclk); #1;
    req = '0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < ((b == 1) ? 4 : 0); s++) begin
        tready = 1'b0;
        @(negedge aclk);
        chk("stall tvalid", tvalid, 1);
        chk("stall tdest", tdest, 1);
        chk("stall tlast", tlast, 0);
        chk("stall tdata", tdata, 32'hB0 + b);
        chk("stall dready", req_dready, 0);
        @(posedge aclk); #1;
      end
      tready = 1'b1;
      @(negedge aclk);
      chk("bp tvalid", tvalid, 1);
      chk("bp tdata", tdata, 32'hB0 + b);
      chk("bp tlast", tlast, b == 3);
      chk("bp dready", req_dready, 4'b0010);
      @(posedge aclk); #1;
      req_data[DW +: DW] = 32'hB0 + b + 1;
    end
    @(negedge aclk);
    chk("bp done", req_done, 4'b0010);
    chk("bp tvalid after", tvalid, 0);
    @(posedge aclk); #1;

    // async reset in the middle of a 5-beat packet from requester 1
    req = 4'b0010; set_len(4);
    @(posedge aclk); #1;
    req = '0;
    @(posedge aclk); #1;
    chk("pre-reset tvalid", tvalid, 1);
    #2 areset = 1'b1;
    #1;
    chk("reset tvalid", tvalid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", req_done, 0);
    @(posedge aclk); #1;
    areset = 1'b0; req = 4'b1111; set_len(0); tready = 1'b1;
    @(negedge aclk);
    chk("post-reset done", req_done, 0);
    chk("post-reset tvalid", tvalid, 0);

    // all requesters busy: strict rotation starting at requester 0
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge aclk);
      if (tvalid && tready) begin
        chk($sformatf("rr pkt%0d tdest", n), tdest, n % N);
        n++;
      end
    end
    chk("rr packet count", n, 8);
    req = '0;
    @(posedge aclk); #1;

    // maximum length packet
    req = 4'b0001; set_len(255);
    @(posedge aclk); #1;
    req = '0;
    beats = 0; lasts = 0; lastpos = 0;
    for (int c = 0; c < 300 && !(beats > 0 && !tvalid); c++) begin
      @(negedge aclk);
      if (tvalid && tready) begin
        beats++;
        if (tlast) begin lasts++; lastpos = beats; end
      end
      @(posedge aclk); #1;
    end
    chk("maxlen beats", beats, 256);
    chk("maxlen tlast count", lasts, 1);
    chk("maxlen tlast position", lastpos, 256);
    chk("maxlen done", req_done, 4'b0001);

    // randomized traffic against the packet-level model
    areset = 1'b1; req = '0;
    @(posedge aclk); #1;
    areset = 1'b0;
    m_valid = 0; m_dest = 0; m_last = N - 1; m_left = 0; m_done = '0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom);
      tready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < N; i++) begin
        req_len[i*LW +: LW] = LW'($urandom_range(0, 3));
        req_data[i*DW +: DW] = {8'(i), 24'(wcnt[i])};
      end
      @(negedge aclk);
      exp_dr = (m_valid && tready) ? N'(1) << m_dest : '0;
      chk("rnd tvalid", tvalid, m_valid);
      chk("rnd busy", busy, m_valid);
      chk("rnd tlast", tlast, m_valid && m_left == 1);
      chk("rnd dready", req_dready, exp_dr);
      chk("rnd done", req_done, m_done);
      if (m_valid) begin
        chk("rnd tdest", tdest, m_dest);
        chk("rnd tdata", tdata, {8'(m_dest), 24'(wcnt[m_dest])});
      end
      nd = '0;
      if (!m_valid) begin
        if (req != '0) begin
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (req[idx]) begin m_dest = idx; break; end
          end
          m_last = m_dest;
          m_left = int'(req_len[m_dest*LW +: LW]) + 1;
          m_valid = 1;
        end
      end else if (tready) begin
        wcnt[m_dest]++;
        if (m_left == 1) begin m_valid = 0; nd[m_dest] = 1'b1; end
        else m_left--;
      end
      m_done = nd;
      @(posedge aclk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
